// File: rtl/score_writer.sv
// Two-player score keeper that mirrors both scores into a display register block
// over a simple write bus, optionally restricting writes to vertical blanking.
module score_writer #(
   parameter int unsigned WIN_SCORE   = 5,
   parameter int unsigned SYNC_WRITES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p1_point_i,
   input  logic        p2_point_i,
   input  logic        clear_i,
   input  logic        vblank_i,
   output logic        MW_o,
   output logic [1:0]  address_o,
   output logic [31:0] data_o,
   output logic [1:0]  winner_o,
   output logic        busy_o
);

   localparam int unsigned SCORE_W = 4;
   localparam int unsigned DATA_W  = 32;
   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR1  = 2'd1,
      WR2  = 2'd2
   } state_t;

   state_t              state, state_n;
   logic [SCORE_W-1:0]  score1, score2, score1_n, score2_n;
   logic                dirty1, dirty2, dirty1_n, dirty2_n;
   logic [1:0]          winner_n;
   logic                mw_n, busy_n;
   logic [1:0]          addr_n;
   logic [DATA_W-1:0]   data_n;
   logic                permit, inc1, inc2, go1, go2, clr1, clr2;

   // Next-state, scoring and registered-output values
   always_comb begin
      state_n  = state;
      score1_n = score1;
      score2_n = score2;
      winner_n = winner_o;
      mw_n     = 1'b0;
      addr_n   = 2'b00;
      data_n   = '0;
      clr1     = 1'b0;
      clr2     = 1'b0;

      permit = vblank_i | (SYNC_WRITES == 0);
      go1    = dirty1 & permit;
      go2    = dirty2 & permit;
      inc1   = p1_point_i & (winner_o == 2'b00) & ~clear_i;
      inc2   = p2_point_i & (winner_o == 2'b00) & ~clear_i;

      unique case (state)
         IDLE: begin
            if (go1)      state_n = WR1;
            else if (go2) state_n = WR2;
         end
         WR1:     state_n = go2 ? WR2 : IDLE;
         WR2:     state_n = go1 ? WR1 : IDLE;
         default: state_n = IDLE;
      endcase

      // Write data is the score held at the edge that enters the write cycle
      if (state_n == WR1) begin
         mw_n   = 1'b1;
         addr_n = 2'b00;
         data_n = DATA_W'(score1);
         clr1   = 1'b1;
      end else if (state_n == WR2) begin
         mw_n   = 1'b1;
         addr_n = 2'b01;
         data_n = DATA_W'(score2);
         clr2   = 1'b1;
      end

      if (clear_i) begin
         score1_n = '0;
         score2_n = '0;
         winner_n = 2'b00;
      end else begin
         if (inc1) score1_n = score1 + SCORE_W'(1);
         if (inc2) score2_n = score2 + SCORE_W'(1);
         if (winner_o == 2'b00)
            winner_n = {score2 >= WIN, score1 >= WIN};
      end

      // A new point or a clear outranks the flag being consumed by a write
      dirty1_n = clear_i | inc1 | (dirty1 & ~clr1);
      dirty2_n = clear_i | inc2 | (dirty2 & ~clr2);
      busy_n   = dirty1_n | dirty2_n | mw_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         score1    <= '0;
         score2    <= '0;
         dirty1    <= 1'b1;
         dirty2    <= 1'b1;
         winner_o  <= 2'b00;
         MW_o      <= 1'b0;
         address_o <= 2'b00;
         data_o    <= '0;
         busy_o    <= 1'b1;
      end else begin
         state     <= state_n;
         score1    <= score1_n;
         score2    <= score2_n;
         dirty1    <= dirty1_n;
         dirty2    <= dirty2_n;
         winner_o  <= winner_n;
         MW_o      <= mw_n;
         address_o <= addr_n;
         data_o    <= data_n;
         busy_o    <= busy_n;
      end
   end

endmodule

// File: tb/tb_score_writer.sv
// Directed bench for score_writer: expected bus writes are queued as stimulus is
// applied and matched by a falling-edge monitor; spot checks cover timing and winner.
module tb_score_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        p1_point_i, p2_point_i, clear_i, vblank_i;
   logic        MW_o;
   logic [1:0]  address_o;
   logic [31:0] data_o;
   logic [1:0]  winner_o;
   logic        busy_o;

   int passed = 0;
   int total  = 0;
   logic [33:0] exp_q[$];

   score_writer #(.WIN_SCORE(5), .SYNC_WRITES(1)) dut (
      .clk(clk), .rst(rst),
      .p1_point_i(p1_point_i), .p2_point_i(p2_point_i),
      .clear_i(clear_i), .vblank_i(vblank_i),
      .MW_o(MW_o), .address_o(address_o), .data_o(data_o),
      .winner_o(winner_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [1:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   // Pulse is sampled at the next rising edge; returns just after that edge
   task automatic pulse(input logic a, input logic b, input logic c);
      p1_point_i = a; p2_point_i = b; clear_i = c;
      tick();
      p1_point_i = 1'b0; p2_point_i = 1'b0; clear_i = 1'b0;
   endtask

   // Bus monitor: every write strobe must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst === 1'b0 && MW_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {33'b0, MW_o}, 34'd0);
         end else begin
            chk("bus_write", {address_o, data_o}, exp_q.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b1;
      p1_point_i = 1'b0; p2_point_i = 1'b0; clear_i = 1'b0; vblank_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {MW_o, address_o, data_o[30:0]}, 34'd0);
      chk("reset_winner_busy", {31'b0, winner_o, busy_o}, 34'd1);

      // Reset release writes zeros to both registers, then goes idle
      push(2'b00, 32'd0);
      push(2'b01, 32'd0);
      rst = 1'b0;
      tick(3);
      chk("post_reset_busy", {33'b0, busy_o}, 34'd0);
      chk("post_reset_drained", 34'(exp_q.size()), 34'd0);

      // Single p1 point: strobe one cycle after the sampling edge
      push(2'b00, 32'd1);
      pulse(1'b1, 1'b0, 1'b0);
      chk("latency_gap", {33'b0, MW_o}, 34'd0);
      tick();
      chk("latency_wr1", {MW_o, address_o, data_o[30:0]}, {1'b1, 2'b00, 31'd1});
      tick();
      chk("no_wr2", {33'b0, MW_o}, 34'd0);

      // Deferred write outside vertical blanking
      vblank_i = 1'b0;
      push(2'b01, 32'd1);
      pulse(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("deferred_no_mw", {33'b0, MW_o}, 34'd0);
         tick();
      end
      chk("deferred_busy", {33'b0, busy_o}, 34'd1);
      vblank_i = 1'b1;
      tick(3);
      chk("deferred_done", {33'b0, busy_o}, 34'd0);

      // Point arriving during the WR1 cycle that writes 2
      push(2'b00, 32'd2);
      push(2'b00, 32'd3);
      pulse(1'b1, 1'b0, 1'b0);
      tick();
      chk("wr1_of_two", {MW_o, data_o[31:0]}, {2'b01, 32'd2});
      pulse(1'b1, 1'b0, 1'b0);
      tick(3);

      // Player 1 reaches 5
      push(2'b00, 32'd4);
      pulse(1'b1, 1'b0, 1'b0);
      tick(3);
      push(2'b00, 32'd5);
      pulse(1'b1, 1'b0, 1'b0);
      tick(3);
      chk("winner_p1", {32'b0, winner_o}, 34'd1);
      pulse(1'b0, 1'b1, 1'b0);
      tick(3);
      chk("p1_won_ignore", {32'b0, winner_o}, 34'd1);

      // Clear, then abort the second clear-write with reset
      push(2'b00, 32'd0);
      push(2'b01, 32'd0);
      pulse(1'b0, 1'b0, 1'b1);
      chk("clear_winner", {32'b0, winner_o}, 34'd0);
      tick(2);
      chk("in_wr2", {MW_o, address_o, data_o[30:0]}, {1'b1, 2'b01, 31'd0});
      rst = 1'b1;
      #1;
      chk("rst_abort", {MW_o, address_o, data_o[30:0]}, 34'd0);
      chk("rst_abort_pending", 34'(exp_q.size()), 34'd1);
      exp_q.delete();
      tick();
      push(2'b00, 32'd0);
      push(2'b01, 32'd0);
      rst = 1'b0;
      tick(3);

      // Simultaneous points up to a draw
      for (int s = 1; s <= 5; s++) begin
         push(2'b00, 32'(s));
         push(2'b01, 32'(s));
         pulse(1'b1, 1'b1, 1'b0);
         tick(3);
      end
      chk("winner_draw", {32'b0, winner_o}, 34'd3);
      pulse(1'b1, 1'b1, 1'b0);
      tick(3);
      chk("draw_ignore", {32'b0, winner_o}, 34'd3);
      chk("final_busy", {33'b0, busy_o}, 34'd0);
      chk("final_drained", 34'(exp_q.size()), 34'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
